// File: rtl/ball_motion_if.sv
// rtl/ball_motion_if.sv - pixel stream, control and status bundle for ball_motion
// Master drives the stream and controls; slave (the ball stage) returns the overlay and position.
interface ball_motion_if;
   logic [25:0] strRGB_i;
   logic        start;
   logic        bounce_x;
   logic [25:0] strRGB_o;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic        miss_l;
   logic        miss_r;

   modport master (
      output strRGB_i, start, bounce_x,
      input  strRGB_o, pos_x, pos_y, miss_l, miss_r
   );

   modport slave (
      input  strRGB_i, start, bounce_x,
      output strRGB_o, pos_x, pos_y, miss_l, miss_r
   );
endinterface

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - moving SIZExSIZE ball overlay with edge bounce, paddle bounce and serve
// Define BALL_SCORE_EN to turn left/right edge hits into misses followed by a timed re-serve.
module ball_motion #(
   parameter int          H_RES       = 640,
   parameter int          V_RES       = 480,
   parameter int          SIZE        = 10,
   parameter int          SPEED_X     = 2,
   parameter int          SPEED_Y     = 1,
   parameter logic [2:0]  COLOR       = 3'b111,
   parameter int          SERVE_DELAY = 60
) (
   input logic           px_clk,
   input logic           reset_n,
   ball_motion_if.slave  bus
);
   localparam logic [10:0] X_MAX = 11'(H_RES - SIZE);
   localparam logic [10:0] Y_MAX = 11'(V_RES - SIZE);
   localparam logic [9:0]  CX    = 10'((H_RES - SIZE) / 2);
   localparam logic [9:0]  CY    = 10'((V_RES - SIZE) / 2);
   localparam logic [10:0] SPX   = 11'(SPEED_X);
   localparam logic [10:0] SPY   = 11'(SPEED_Y);
   localparam logic [10:0] SZ    = 11'(SIZE);

`ifdef BALL_SCORE_EN
   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SERVE} state_t;
   logic [7:0] r_cnt;
`else
   typedef enum logic [1:0] {S_IDLE, S_MOVE} state_t;
`endif

   state_t      r_state;
   logic [9:0]  r_pos_x, r_pos_y;
   logic        r_dir_x, r_dir_y;
   logic        r_bounce;
   logic        r_miss_l, r_miss_r;
   logic [25:0] r_out;

   logic [10:0] w_x, w_y, w_px, w_py;
   logic        w_tick, w_cover, w_bounce, w_dx, w_go;
   logic        w_x_hit, w_y_hit;
   logic [9:0]  w_x_next, w_y_next;

   assign w_x    = {1'b0, bus.strRGB_i[22:13]};
   assign w_y    = {1'b0, bus.strRGB_i[12:3]};
   assign w_px   = {1'b0, r_pos_x};
   assign w_py   = {1'b0, r_pos_y};
   assign w_tick = (bus.strRGB_i[22:13] == 10'd0) && (bus.strRGB_i[12:3] == 10'(V_RES));

   assign w_cover = (w_x >= w_px) && (w_x < w_px + SZ) &&
                    (w_y >= w_py) && (w_y < w_py + SZ);

   // A paddle bounce turns the ball before this tick's step is taken.
   assign w_bounce = (r_state == S_MOVE) && (r_bounce || bus.bounce_x);
   assign w_dx     = r_dir_x ^ w_bounce;
   assign w_go     = w_tick && ((r_state == S_MOVE) || ((r_state == S_IDLE) && bus.start));

   assign w_x_hit  = w_dx ? (w_px + SPX >= X_MAX) : (w_px <= SPX);
   assign w_x_next = w_x_hit ? (w_dx ? X_MAX[9:0] : 10'd0)
                             : (w_dx ? 10'(w_px + SPX) : 10'(w_px - SPX));
   assign w_y_hit  = r_dir_y ? (w_py + SPY >= Y_MAX) : (w_py <= SPY);
   assign w_y_next = w_y_hit ? (r_dir_y ? Y_MAX[9:0] : 10'd0)
                             : (r_dir_y ? 10'(w_py + SPY) : 10'(w_py - SPY));

   always_ff @(posedge px_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_pos_x  <= CX;
         r_pos_y  <= CY;
         r_dir_x  <= 1'b1;
         r_dir_y  <= 1'b1;
         r_bounce <= 1'b0;
         r_miss_l <= 1'b0;
         r_miss_r <= 1'b0;
         r_out    <= '0;
`ifdef BALL_SCORE_EN
         r_cnt    <= '0;
`endif
      end else begin
         r_out    <= {(w_cover ? COLOR : bus.strRGB_i[25:23]), bus.strRGB_i[22:0]};
         r_miss_l <= 1'b0;
         r_miss_r <= 1'b0;

         if (w_tick)
            r_bounce <= 1'b0;
         else if ((r_state == S_MOVE) && bus.bounce_x)
            r_bounce <= 1'b1;

         if (w_tick && (r_state == S_IDLE) && bus.start)
            r_state <= S_MOVE;

         if (w_go) begin
            r_pos_y <= w_y_next;
            r_dir_y <= r_dir_y ^ w_y_hit;
`ifdef BALL_SCORE_EN
            if (w_x_hit) begin
               // Serve back toward the side that just scored.
               r_miss_l <= ~w_dx;
               r_miss_r <= w_dx;
               r_dir_x  <= ~w_dx;
               r_pos_x  <= CX;
               r_pos_y  <= CY;
               r_cnt    <= '0;
               r_state  <= S_SERVE;
            end else begin
               r_pos_x  <= w_x_next;
               r_dir_x  <= w_dx;
            end
`else
            r_pos_x <= w_x_next;
            r_dir_x <= r_dir_x ^ (w_bounce | w_x_hit);
`endif
         end

`ifdef BALL_SCORE_EN
         if (w_tick && (r_state == S_SERVE)) begin
            if (r_cnt == 8'(SERVE_DELAY - 1)) begin
               r_cnt   <= '0;
               r_state <= S_MOVE;
            end else begin
               r_cnt   <= r_cnt + 8'd1;
            end
         end
`endif
      end
   end

   assign bus.strRGB_o = r_out;
   assign bus.pos_x    = r_pos_x;
   assign bus.pos_y    = r_pos_y;
   assign bus.miss_l   = r_miss_l;
   assign bus.miss_r   = r_miss_r;
endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - directed, table-driven bench for ball_motion with default parameters
// Ball path from centre: right 2/frame, down 1/frame; hand-derived frame indices are used below.
module tb_ball_motion;
   logic px_clk  = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   ball_motion_if bus ();

   ball_motion dut (
      .px_clk  (px_clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 px_clk = ~px_clk;

   typedef struct {
      logic [2:0] rgb;
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] fl;
      logic [2:0] exp_rgb;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   task automatic set_px(input logic [2:0] rgb, input logic [9:0] x, input logic [9:0] y,
                         input logic [2:0] fl);
      bus.strRGB_i = {rgb, x, y, fl};
   endtask

   // Tick pixel for one cycle; on return the post-tick outputs are visible.
   task automatic tick();
      set_px(3'd0, 10'd0, 10'd480, 3'd0);
      @(negedge px_clk);
      set_px(3'd0, 10'd1023, 10'd1023, 3'd0);
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         tick();
         @(negedge px_clk);
      end
   endtask

   task automatic pulse_bounce();
      bus.bounce_x = 1'b1;
      @(negedge px_clk);
      bus.bounce_x = 1'b0;
      repeat (2) @(negedge px_clk);
   endtask

   task automatic check_pos(input string name, input int ex, input int ey);
      check({name, " pos_x"}, 32'(bus.pos_x), 32'(ex));
      check({name, " pos_y"}, 32'(bus.pos_y), 32'(ey));
   endtask

   initial begin
      vecs[0] = '{3'b010, 10'd314, 10'd235, 3'd5, 3'b010};
      vecs[1] = '{3'b010, 10'd315, 10'd235, 3'd2, 3'b111};
      vecs[2] = '{3'b001, 10'd324, 10'd244, 3'd0, 3'b111};
      vecs[3] = '{3'b001, 10'd325, 10'd235, 3'd1, 3'b001};
      vecs[4] = '{3'b100, 10'd315, 10'd234, 3'd3, 3'b100};
      vecs[5] = '{3'b100, 10'd315, 10'd245, 3'd4, 3'b100};
      vecs[6] = '{3'b011, 10'd320, 10'd240, 3'd7, 3'b111};
      vecs[7] = '{3'b000, 10'd324, 10'd245, 3'd6, 3'b000};

      bus.start    = 1'b0;
      bus.bounce_x = 1'b0;
      set_px(3'b101, 10'd315, 10'd235, 3'd7);
      repeat (3) @(negedge px_clk);
      check("reset strRGB_o", 32'(bus.strRGB_o), 32'd0);
      check_pos("reset", 315, 235);
      check("reset miss_l", 32'(bus.miss_l), 32'd0);
      check("reset miss_r", 32'(bus.miss_r), 32'd0);

      reset_n = 1'b1;
      set_px(3'd0, 10'd1023, 10'd1023, 3'd0);
      @(negedge px_clk);
      tick_n(2);
      check_pos("idle 2 frames", 315, 235);

      // Output must show the previous cycle's vector: neither the current nor an older one.
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) set_px(vecs[i].rgb, vecs[i].x, vecs[i].y, vecs[i].fl);
         else       set_px(3'd0, 10'd1023, 10'd1023, 3'd0);
         #1;
         if (i > 0)
            check($sformatf("draw vec %0d", i - 1), 32'(bus.strRGB_o),
                  32'({vecs[i-1].exp_rgb, vecs[i-1].x, vecs[i-1].y, vecs[i-1].fl}));
         @(negedge px_clk);
      end

      pulse_bounce();
      bus.start = 1'b1;
      tick_n(1);
      check_pos("move k1", 317, 236);
      tick_n(9);
      check_pos("move k10", 335, 245);
      tick_n(147);
      check("k157 pos_x", 32'(bus.pos_x), 32'd629);
      tick_n(1);
      check("k158 right clamp", 32'(bus.pos_x), 32'd630);
      tick_n(1);
      check("k159 leftward", 32'(bus.pos_x), 32'd628);
      tick_n(75);
      check("k234 pos_y", 32'(bus.pos_y), 32'd469);
      tick_n(1);
      check("k235 bottom clamp", 32'(bus.pos_y), 32'd470);
      tick_n(1);
      check("k236 upward", 32'(bus.pos_y), 32'd469);
      tick_n(236);
      check_pos("k472", 2, 233);

      tick();
`ifdef BALL_SCORE_EN
      check("miss_l pulse", 32'(bus.miss_l), 32'd1);
      check("miss_r quiet", 32'(bus.miss_r), 32'd0);
      check_pos("miss recentre", 315, 235);
      @(negedge px_clk);
      check("miss_l one cycle", 32'(bus.miss_l), 32'd0);
      tick_n(59);
      check_pos("serve s59", 315, 235);
      tick_n(1);
      check_pos("serve s60", 315, 235);
      tick_n(1);
      check_pos("serve resume", 317, 234);
      tick_n(1);
      check("serve s62", 32'(bus.pos_x), 32'd319);
      pulse_bounce();
      tick_n(1);
      check("bounce_x turn", 32'(bus.pos_x), 32'd317);
`else
      check_pos("left clamp", 0, 232);
      check("miss_l tied", 32'(bus.miss_l), 32'd0);
      @(negedge px_clk);
      check("miss_l still 0", 32'(bus.miss_l), 32'd0);
      tick_n(1);
      check("k474 rightward", 32'(bus.pos_x), 32'd2);
      tick_n(199);
      check_pos("k673", 400, 32);
      pulse_bounce();
      tick_n(1);
      check_pos("bounce_x turn", 398, 31);
`endif

      set_px(3'b010, 10'd100, 10'd100, 3'd3);
      @(posedge px_clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset strRGB_o", 32'(bus.strRGB_o), 32'd0);
      check_pos("async reset", 315, 235);
      check("async reset miss_l", 32'(bus.miss_l), 32'd0);
      @(negedge px_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
